// File: rtl/instr_queue.sv
// instr_queue: in-order fetch queue. Holds the fetch PC, captures words from a
// combinational instruction memory into a circular FIFO and presents the oldest
// entry to decode through a valid/ready handshake. Redirect flushes and refetches.
module instr_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     issue_valid,
    output logic [31:0]              issue_instr,
    output logic [31:0]              issue_pc,
    input  logic                     issue_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   epc_mem   [DEPTH];
    logic          enq;
    logic          deq;

    // Redirect masks both sides of the queue in its cycle; a full queue never
    // enqueues, even when a dequeue frees a slot on the same edge.
    assign issue_valid = (count != '0) && !redirect;
    assign deq         = issue_valid && issue_ready;
    assign enq         = (count != CNT_FULL) && !redirect;

    // Outputs come straight from storage, never from imem_rdata.
    assign imem_addr   = pc;
    assign issue_instr = instr_mem[head];
    assign issue_pc    = epc_mem[head];

    // Control state: fetch PC, pointers and occupancy, with redirect taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= PC_RESET;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) head <= head + PTR_ONE;
            if (enq) begin
                tail <= tail + PTR_ONE;
                pc   <= pc + 32'd4;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: contents are don't-care after reset/flush, so no reset here.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[tail] <= imem_rdata;
            epc_mem[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized stimulus against a queue-based reference model;
// a negedge monitor compares DUT outputs with the model's expected head/state.
module tb_instr_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    ent_t        mq[$];
    logic [31:0] mpc;

    instr_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
        .issue_ready(issue_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    // Memory contents: a scramble of the address so instr and pc differ.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = memf(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched entries, updated with the pre-edge inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc = PC_RESET;
        end else if (redirect) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            automatic bit do_enq = mq.size() < DEPTH;
            if (mq.size() != 0 && issue_ready) void'(mq.pop_front());
            if (do_enq) begin
                mq.push_back('{pc: mpc, instr: memf(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    end

    // Monitor: mid-cycle compare of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit ev = (mq.size() != 0) && !redirect;
            check("count", 32'(count), 32'(mq.size()));
            check("issue_valid", 32'(issue_valid), 32'(ev));
            check("imem_addr", imem_addr, mpc);
            if (ev) begin
                check("issue_pc", issue_pc, mq[0].pc);
                check("issue_instr", issue_instr, mq[0].instr);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic red, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        issue_ready = rdy;
        redirect    = red;
        redirect_pc = rpc;
    endtask

    initial begin
        // Reset, then fill with decode stalled.
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) cyc(1'b0, 1'b0, '0);
        // Full with a single dequeue pulse.
        cyc(1'b1, 1'b0, '0);
        repeat (2) cyc(1'b0, 1'b0, '0);
        // Streaming.
        repeat (12) cyc(1'b1, 1'b0, '0);
        // Toggling ready across pointer wrap.
        for (int i = 0; i < 20; i++) cyc(i[0] ? 1'b0 : 1'b1, 1'b0, '0);
        // Redirect to unaligned target with ready high.
        cyc(1'b1, 1'b1, 32'h0000_0103);
        repeat (6) cyc(1'b1, 1'b0, '0);
        // Random traffic including redirects near the top of the address space.
        for (int i = 0; i < 800; i++) begin
            automatic logic r   = ($urandom_range(0, 3) != 0);
            automatic logic red = ($urandom_range(0, 15) == 0);
            automatic logic [31:0] t = ($urandom_range(0, 3) == 0) ?
                                       (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(r, red, t);
        end
        // Build count = 2, then assert reset between edges.
        cyc(1'b0, 1'b1, 32'h0000_0200);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_valid", 32'(issue_valid), 32'd0);
        check("async_addr", imem_addr, PC_RESET);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) cyc(($urandom_range(0, 1) == 1), 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
